// File: rtl/rtmc_pkg.sv
// Shared widths, command-byte layout and SPI target state encoding for the rtmc register interface.
package rtmc_pkg;

  localparam int unsigned RTMC_ADDR_W        = 7;
  localparam int unsigned RTMC_DATA_W        = 8;
  localparam int unsigned RTMC_CMD_WRITE_BIT = 7;
  localparam int unsigned RTMC_BIT_CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

endpackage

// File: rtl/rtmc_sync.sv
// Multi-stage flip-flop synchronizer for one asynchronous input pin.
module rtmc_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rtmc_spi_target.sv
// SPI mode-0 target: decodes {rw, addr} command frames into single-cycle register-bus strobes
// with auto-incrementing burst reads and writes.
module rtmc_spi_target
  import rtmc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sck,
  input  logic                   cs_n,
  input  logic                   sdi,
  output logic                   sdo,
  output logic [RTMC_ADDR_W-1:0] reg_addr,
  output logic [RTMC_DATA_W-1:0] reg_wdata,
  output logic                   reg_we,
  output logic                   reg_re,
  input  logic [RTMC_DATA_W-1:0] reg_rdata
);

  logic w_sck_s, w_cs_s, w_sdi_s;

  rtmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .i_d(sck),  .o_q(w_sck_s));
  rtmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_d(cs_n), .o_q(w_cs_s));
  rtmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .i_d(sdi),  .o_q(w_sdi_s));

  logic                      r_sck_d, r_rise, r_fall, r_sdi_d, r_re_d, r_armed;
  logic [SYNC_STAGES-1:0]    r_flush;
  spi_state_t                r_state, w_state_nxt;
  logic [RTMC_BIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [RTMC_DATA_W-1:0]    r_rx, w_rx_nxt, r_tx, w_tx_nxt, w_byte;
  logic [RTMC_ADDR_W-1:0]    r_addr, w_addr_nxt, r_reg_addr, w_reg_addr_nxt;
  logic [RTMC_DATA_W-1:0]    r_wdata, w_wdata_nxt;
  logic                      r_rw, w_rw_nxt, r_sdo, w_sdo_nxt;
  logic                      r_we, w_we_nxt, r_re, w_re_nxt;

  // Edge pulses are registered so sdi is sampled with the same alignment as sck.
  // r_armed stays low until the synchronizers have flushed and cs_n is seen high,
  // so a frame already in progress at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_d <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_sdi_d <= 1'b0;
      r_re_d  <= 1'b0;
      r_flush <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sck_d <= w_sck_s;
      r_rise  <= w_sck_s & ~r_sck_d;
      r_fall  <= ~w_sck_s & r_sck_d;
      r_sdi_d <= w_sdi_s;
      r_re_d  <= r_re;
      r_flush <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_armed <= r_armed | (r_flush[SYNC_STAGES-1] & w_cs_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_sdo      <= 1'b0;
      r_reg_addr <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rx       <= w_rx_nxt;
      r_tx       <= w_tx_nxt;
      r_addr     <= w_addr_nxt;
      r_rw       <= w_rw_nxt;
      r_sdo      <= w_sdo_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_we       <= w_we_nxt;
      r_re       <= w_re_nxt;
    end
  end

  assign w_byte = {r_rx[RTMC_DATA_W-2:0], r_sdi_d};

  // r_addr always holds the address of the next strobe in the burst.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rx_nxt       = r_rx;
    w_tx_nxt       = r_tx;
    w_addr_nxt     = r_addr;
    w_rw_nxt       = r_rw;
    w_sdo_nxt      = r_sdo;
    w_reg_addr_nxt = r_reg_addr;
    w_wdata_nxt    = r_wdata;
    w_we_nxt       = 1'b0;
    w_re_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        w_sdo_nxt = 1'b0;
        w_tx_nxt  = '0;
        w_cnt_nxt = '0;
        if (r_armed && !w_cs_s) begin
          w_state_nxt = CMD;
        end
      end
      CMD: begin
        w_sdo_nxt = 1'b0;
        if (w_cs_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_rise) begin
          w_rx_nxt  = w_byte;
          w_cnt_nxt = r_cnt + RTMC_BIT_CNT_W'(1);
          if (r_cnt == RTMC_BIT_CNT_W'(7)) begin
            w_state_nxt = DATA;
            w_rw_nxt    = w_byte[RTMC_CMD_WRITE_BIT];
            if (w_byte[RTMC_CMD_WRITE_BIT]) begin
              w_addr_nxt = w_byte[RTMC_ADDR_W-1:0];
            end else begin
              w_re_nxt       = 1'b1;
              w_reg_addr_nxt = w_byte[RTMC_ADDR_W-1:0];
              w_addr_nxt     = w_byte[RTMC_ADDR_W-1:0] + RTMC_ADDR_W'(1);
            end
          end
        end
      end
      DATA: begin
        if (w_cs_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_sdo_nxt   = 1'b0;
        end else begin
          if (r_re_d) begin
            w_tx_nxt = reg_rdata;
          end else if (r_fall) begin
            w_sdo_nxt = r_tx[RTMC_DATA_W-1];
            w_tx_nxt  = {r_tx[RTMC_DATA_W-2:0], 1'b0};
          end
          if (r_rise) begin
            w_rx_nxt  = w_byte;
            w_cnt_nxt = r_cnt + RTMC_BIT_CNT_W'(1);
            if (r_cnt == RTMC_BIT_CNT_W'(7)) begin
              w_reg_addr_nxt = r_addr;
              w_addr_nxt     = r_addr + RTMC_ADDR_W'(1);
              if (r_rw) begin
                w_we_nxt    = 1'b1;
                w_wdata_nxt = w_byte;
              end else begin
                w_re_nxt = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign sdo       = r_sdo;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;

endmodule

// File: tb/tb_rtmc_spi_target.sv
// Scoreboard bench for rtmc_spi_target: an SPI host model drives frames, expected strobes are
// queued up front and matched as the DUT issues them; read data comes from a small register model.
module tb_rtmc_spi_target;

  logic       clk = 1'b0;
  logic       rst_n, sck, cs_n, sdi, sdo;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       reg_we, reg_re;

  int n_tests = 0;
  int n_fail  = 0;
  int half_cyc = 6;

  logic [14:0] we_q[$];
  logic [6:0]  re_q[$];

  rtmc_spi_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_model(input logic [6:0] a);
    if (a == 7'h12) return 8'hA5;
    return {1'b0, a} ^ 8'hFF;
  endfunction

  // Register-file model: data valid the cycle after reg_re, held until the next read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_rdata <= 8'h00;
    else if (reg_re) reg_rdata <= rd_model(reg_addr);
  end

  // Strobe monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    logic [14:0] exp_we;
    logic [6:0]  exp_re;
    if (reg_we && reg_re) begin
      n_tests++; n_fail++;
      $display("FAIL strobe_overlap: reg_we and reg_re both high, required mutually exclusive");
    end
    if (reg_we) begin
      n_tests++;
      if (we_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_we: addr=%h data=%h, required no write", reg_addr, reg_wdata);
      end else begin
        exp_we = we_q.pop_front();
        if ({reg_addr, reg_wdata} !== exp_we) begin
          n_fail++;
          $display("FAIL write_strobe: addr=%h data=%h, required addr=%h data=%h",
                   reg_addr, reg_wdata, exp_we[14:8], exp_we[7:0]);
        end
      end
    end
    if (reg_re) begin
      n_tests++;
      if (re_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_re: addr=%h, required no read", reg_addr);
      end else begin
        exp_re = re_q.pop_front();
        if (reg_addr !== exp_re) begin
          n_fail++;
          $display("FAIL read_strobe: addr=%h, required addr=%h", reg_addr, exp_re);
        end
      end
    end
  end

  // Mode-0 host: sdi set while sck low, sdo sampled just before each rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic [7:0] acc = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[7-i];
      repeat (half_cyc) @(negedge clk);
      acc = {acc[6:0], sdo};
      sck = 1'b1;
      repeat (half_cyc) @(negedge clk);
      sck = 1'b0;
    end
    rx = acc;
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (half_cyc) @(negedge clk);
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({sdo, reg_we, reg_re} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: sdo/we/re=%b, required 000", {sdo, reg_we, reg_re});
    end
    n_tests++;
    if ({reg_addr, reg_wdata} !== 15'h0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h wdata=%h, required 00 00", reg_addr, reg_wdata);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [7:0] rx0, rx1;
    half_cyc = 6;
    we_q.push_back({7'h05, 8'h3C});
    cs_start();
    spi_bits(8'h85, 8, rx0);
    spi_bits(8'h3C, 8, rx1);
    cs_end();
    n_tests++;
    if ({rx0, rx1} !== 16'h0000) begin
      n_fail++; $display("FAIL write_sdo: got %h %h, required 00 00", rx0, rx1);
    end
    n_tests++;
    if (we_q.size() + re_q.size() != 0) begin
      n_fail++; $display("FAIL single_write_drain: %0d strobes missing, required 0", we_q.size() + re_q.size());
    end
  endtask

  task automatic test_single_read();
    logic [7:0] rx0, rx1;
    half_cyc = 6;
    // The dummy byte's boundary prefetches the next address.
    re_q.push_back(7'h12);
    re_q.push_back(7'h13);
    cs_start();
    spi_bits(8'h12, 8, rx0);
    spi_bits(8'h00, 8, rx1);
    cs_end();
    n_tests++;
    if (rx0 !== 8'h00) begin
      n_fail++; $display("FAIL read_cmd_sdo: got %h, required 00", rx0);
    end
    n_tests++;
    if (rx1 !== 8'hA5) begin
      n_fail++; $display("FAIL single_read_data: got %h, required a5", rx1);
    end
    n_tests++;
    if (we_q.size() + re_q.size() != 0) begin
      n_fail++; $display("FAIL single_read_drain: %0d strobes missing, required 0", we_q.size() + re_q.size());
    end
  endtask

  task automatic test_burst_write_wrap();
    logic [7:0] rx;
    logic [7:0] data[3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] acc = 8'h00;
    half_cyc = 5;
    we_q.push_back({7'h7E, 8'h11});
    we_q.push_back({7'h7F, 8'h22});
    we_q.push_back({7'h00, 8'h33});
    cs_start();
    spi_bits(8'hFE, 8, rx);
    for (int i = 0; i < 3; i++) begin
      spi_bits(data[i], 8, rx);
      acc = acc | rx;
    end
    cs_end();
    n_tests++;
    if (acc !== 8'h00) begin
      n_fail++; $display("FAIL burst_write_sdo: or of bytes %h, required 00", acc);
    end
    n_tests++;
    if (we_q.size() + re_q.size() != 0) begin
      n_fail++; $display("FAIL burst_write_drain: %0d strobes missing, required 0", we_q.size() + re_q.size());
    end
  endtask

  task automatic test_burst_read_max();
    logic [7:0] rx;
    half_cyc = 4;
    for (int a = 8'h40; a <= 8'h43; a++) re_q.push_back(7'(a));
    cs_start();
    spi_bits(8'h40, 8, rx);
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'h00, 8, rx);
      n_tests++;
      if (rx !== (8'hBF - 8'(i))) begin
        n_fail++; $display("FAIL burst_read_byte%0d: got %h, required %h", i, rx, 8'hBF - 8'(i));
      end
    end
    cs_end();
    n_tests++;
    if (we_q.size() + re_q.size() != 0) begin
      n_fail++; $display("FAIL burst_read_drain: %0d strobes missing, required 0", we_q.size() + re_q.size());
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    half_cyc = 6;
    cs_start();
    spi_bits(8'h81, 8, rx);
    spi_bits(8'hF8, 5, rx);
    cs_end();
    we_q.push_back({7'h01, 8'h77});
    cs_start();
    spi_bits(8'h81, 8, rx);
    spi_bits(8'h77, 8, rx);
    cs_end();
    n_tests++;
    if (we_q.size() + re_q.size() != 0) begin
      n_fail++; $display("FAIL abort_drain: %0d strobes missing, required 0", we_q.size() + re_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx;
    half_cyc = 6;
    cs_start();
    spi_bits(8'h85, 8, rx);
    spi_bits(8'h3C, 4, rx);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sdo, reg_we, reg_re, reg_addr, reg_wdata} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: sdo=%b we=%b re=%b addr=%h wdata=%h, required all 0",
               sdo, reg_we, reg_re, reg_addr, reg_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spi_bits(8'hC0, 4, rx);
    spi_bits(8'h99, 8, rx);
    cs_end();
    we_q.push_back({7'h03, 8'h5A});
    cs_start();
    spi_bits(8'h83, 8, rx);
    spi_bits(8'h5A, 8, rx);
    cs_end();
    n_tests++;
    if (we_q.size() + re_q.size() != 0) begin
      n_fail++; $display("FAIL reset_recover_drain: %0d strobes missing, required 0", we_q.size() + re_q.size());
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write_wrap();
    test_burst_read_max();
    test_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
